// File: rtl/quad_pulse_pkg.sv
// Shared constants and step decode for the quadrature pulse front end.
package quad_pulse_pkg;

  typedef enum logic [1:0] {
    QS_00 = 2'b00,
    QS_01 = 2'b01,
    QS_11 = 2'b11,
    QS_10 = 2'b10
  } quad_state_e;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_FWD,
    STEP_REV,
    STEP_ILLEGAL
  } step_e;

  // Successor of a state in the forward Gray sequence 00->01->11->10->00.
  function automatic quad_state_e next_fwd(input quad_state_e s);
    quad_state_e n;
    n = QS_01;
    case (s)
      QS_00:   n = QS_01;
      QS_01:   n = QS_11;
      QS_11:   n = QS_10;
      QS_10:   n = QS_00;
      default: n = QS_01;
    endcase
    return n;
  endfunction

  // Classify a prev->cur move; a two-bit change is illegal.
  function automatic step_e decode_step(input logic [1:0] prev_ab,
                                        input logic [1:0] cur_ab);
    step_e step;
    step = STEP_ILLEGAL;
    if (prev_ab == cur_ab)
      step = STEP_NONE;
    else if (cur_ab == next_fwd(quad_state_e'(prev_ab)))
      step = STEP_FWD;
    else if (prev_ab == next_fwd(quad_state_e'(cur_ab)))
      step = STEP_REV;
    return step;
  endfunction

endpackage

// File: rtl/glitch_filter.sv
// Two-flop synchronizer followed by a stable-cycle glitch filter for one channel.
module glitch_filter #(
  parameter int unsigned FILTER_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_raw,
  input  logic [FILTER_W-1:0] i_filter_len,
  output logic                o_filt
);

  logic                r_sync1;
  logic                r_sync2;
  logic [FILTER_W-1:0] r_cnt;
  logic                r_filt;

  // Level is accepted once it has differed for filter_len+1 consecutive cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_cnt   <= '0;
      r_filt  <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt >= i_filter_len) begin
        r_filt <= r_sync2;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + FILTER_W'(1);
      end
    end
  end

  assign o_filt = r_filt;

endmodule

// File: rtl/quad_pulse_frontend.sv
// Quadrature encoder front end: filtered A/B, x4 step decode, illegal-move counting.
module quad_pulse_frontend
  import quad_pulse_pkg::*;
#(
  parameter int unsigned FILTER_W = 8,
  parameter int unsigned ERR_W    = 8
) (
  input  logic                s00_axi_aclk,
  input  logic                s00_axi_aresetn,
  input  logic                enc_a,
  input  logic                enc_b,
  input  logic                enable,
  input  logic [FILTER_W-1:0] filter_len,
  input  logic                err_clr,
  output logic                pulse_valid,
  output logic                pulse_dir,
  output logic                err_valid,
  output logic [ERR_W-1:0]    err_cnt,
  output logic                a_filt,
  output logic                b_filt
);

  logic             w_a_filt;
  logic             w_b_filt;
  logic [1:0]       w_cur_ab;
  step_e            w_step;
  logic             w_pulse_valid_nxt;
  logic             w_pulse_dir_nxt;
  logic             w_err_valid_nxt;
  logic [ERR_W-1:0] w_err_cnt_nxt;

  logic [1:0]       r_prev_ab;
  logic             r_pulse_valid;
  logic             r_pulse_dir;
  logic             r_err_valid;
  logic [ERR_W-1:0] r_err_cnt;

  glitch_filter #(.FILTER_W(FILTER_W)) u_filt_a (
    .clk          (s00_axi_aclk),
    .rst_n        (s00_axi_aresetn),
    .i_raw        (enc_a),
    .i_filter_len (filter_len),
    .o_filt       (w_a_filt)
  );

  glitch_filter #(.FILTER_W(FILTER_W)) u_filt_b (
    .clk          (s00_axi_aclk),
    .rst_n        (s00_axi_aresetn),
    .i_raw        (enc_b),
    .i_filter_len (filter_len),
    .o_filt       (w_b_filt)
  );

  assign w_cur_ab = {w_a_filt, w_b_filt};
  assign w_step   = decode_step(r_prev_ab, w_cur_ab);

  // Strobe and counter next-state; direction holds between strobes.
  always_comb begin
    w_pulse_valid_nxt = 1'b0;
    w_pulse_dir_nxt   = r_pulse_dir;
    w_err_valid_nxt   = 1'b0;
    w_err_cnt_nxt     = r_err_cnt;
    if (enable) begin
      case (w_step)
        STEP_FWD: begin
          w_pulse_valid_nxt = 1'b1;
          w_pulse_dir_nxt   = DIR_FWD;
        end
        STEP_REV: begin
          w_pulse_valid_nxt = 1'b1;
          w_pulse_dir_nxt   = DIR_REV;
        end
        STEP_ILLEGAL: w_err_valid_nxt = 1'b1;
        default:      w_pulse_valid_nxt = 1'b0;
      endcase
    end
    if (err_clr)
      w_err_cnt_nxt = '0;
    else if (r_err_valid && (r_err_cnt != {ERR_W{1'b1}}))
      w_err_cnt_nxt = r_err_cnt + ERR_W'(1);
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_prev_ab     <= 2'b00;
      r_pulse_valid <= 1'b0;
      r_pulse_dir   <= 1'b0;
      r_err_valid   <= 1'b0;
      r_err_cnt     <= '0;
    end else begin
      r_prev_ab     <= w_cur_ab;
      r_pulse_valid <= w_pulse_valid_nxt;
      r_pulse_dir   <= w_pulse_dir_nxt;
      r_err_valid   <= w_err_valid_nxt;
      r_err_cnt     <= w_err_cnt_nxt;
    end
  end

  assign pulse_valid = r_pulse_valid;
  assign pulse_dir   = r_pulse_dir;
  assign err_valid   = r_err_valid;
  assign err_cnt     = r_err_cnt;
  assign a_filt      = w_a_filt;
  assign b_filt      = w_b_filt;

endmodule

// File: doc/quad_pulse_frontend.md
QUAD_PULSE_FRONTEND -- requirements
Module: quad_pulse_frontend

Interface
REQ-001 SHALL have parameter FILTER_W, default 8, width of the glitch-filter length and counters.
REQ-002 SHALL have parameter ERR_W, default 8, width of the saturating error counter.
REQ-003 SHALL have port s00_axi_aclk  input  1  the single clock; all state on its rising edge.
REQ-004 SHALL have port s00_axi_aresetn  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port enc_a  input  1  raw encoder channel A, asynchronous to the clock.
REQ-006 SHALL have port enc_b  input  1  raw encoder channel B, asynchronous to the clock.
REQ-007 SHALL have port enable  input  1  decode enable from the PulseCounter register file.
REQ-008 SHALL have port filter_len  input  FILTER_W  stable-cycle threshold minus one.
REQ-009 SHALL have port err_clr  input  1  single-cycle clear of err_cnt.
REQ-010 SHALL have port pulse_valid  output  1  single-cycle count strobe to the PulseCounter core.
REQ-011 SHALL have port pulse_dir  output  1  direction for the strobe: 1 forward, 0 reverse.
REQ-012 SHALL have port err_valid  output  1  single-cycle illegal-transition strobe.
REQ-013 SHALL have port err_cnt  output  ERR_W  saturating illegal-transition count.
REQ-014 SHALL have ports a_filt and b_filt  output  1 each  filtered channel levels.

Function
REQ-015 SHALL pass each of enc_a and enc_b through a 2-flop synchronizer before any other use.
REQ-016 SHALL keep, per channel, a FILTER_W-bit stability counter that increments each cycle the synchronized level differs from the filtered level.
REQ-017 SHALL update the filtered level, and clear the counter, on the edge where the counter is >= filter_len while the levels still differ.
REQ-018 SHALL clear the counter when the synchronized level equals the filtered level, so a glitch shorter than filter_len+1 cycles is rejected.
REQ-019 SHALL register the previous filtered pair {a,b} as prev_ab; on enable low, prev_ab loads the current filtered pair every cycle and no strobes are produced.
REQ-020 SHALL, with enable high, decode prev_ab->cur_ab: 00->01->11->10->00 is forward, the reverse sequence is reverse, and each step gives one pulse_valid with the matching pulse_dir (x4 decoding).
REQ-021 SHALL treat a transition where both bits change in one cycle as illegal: err_valid pulses, pulse_valid stays low, and prev_ab still updates.
REQ-022 SHALL produce no strobe when cur_ab equals prev_ab.
REQ-023 SHALL assert pulse_valid on edge k+3+filter_len, where edge k is the first edge at which the synchronizer samples a new raw level that then stays stable.
REQ-024 SHALL hold pulse_dir at its last value when pulse_valid is low.
REQ-025 SHALL increment err_cnt on err_valid, saturating at all-ones.
REQ-026 SHALL clear err_cnt on err_clr; err_clr wins over a simultaneous err_valid.
REQ-027 SHALL apply a filter_len change from the next cycle; lowering it below an in-progress count updates the level on that next cycle.

Reset
REQ-028 SHALL, on s00_axi_aresetn low, asynchronously clear synchronizers, filtered levels, stability counters, prev_ab, pulse_valid, pulse_dir, err_valid and err_cnt to 0.
REQ-029 SHALL drop in-progress filter counts on reset mid-operation, with no strobe emitted; software holds enable low until the filtered levels have settled.

Structure
REQ-030 SHALL place the quadrature state encodings (2'b00, 2'b01, 2'b11, 2'b10) and the direction constants (DIR_FWD=1, DIR_REV=0) in package quad_pulse_pkg.
REQ-031 SHALL implement the synchronizer plus stability filter as sub-module glitch_filter, instantiated once per channel.
REQ-032 SHALL register every output, with no combinational path from any input to any output.

Verification
REQ-033 SHALL test forward sequencing: filter_len=2, enable=1, A/B stepped 00->01->11->10->00 with each step held 10 cycles -> 4 pulse_valid with pulse_dir=1, each on edge k+5 after its step.
REQ-034 SHALL test reverse sequencing: the same sequence applied in reverse -> 4 pulse_valid with pulse_dir=0, err_cnt=0.
REQ-035 SHALL test glitch rejection: filter_len=4, a 4-cycle high pulse on enc_a -> no strobe and a_filt stays 0; a 6-cycle high pulse -> a_filt rises.
REQ-036 SHALL test illegal transitions: A and B toggled in the same cycle from 00 to 11, 300 times -> 300 err_valid, no pulse_valid, err_cnt=255 (saturated); then err_clr -> err_cnt=0.
REQ-037 SHALL test enable gating: enable=0 over 3 steps, then enable=1 -> no strobes at all, including none at the enable rising edge; the next step gives exactly 1 pulse.
REQ-038 SHALL test reset mid-filter: s00_axi_aresetn asserted while a counter is at 3 -> all outputs 0 immediately, with no strobe after release.
